// File: rtl/memory_param_if.sv
// -----------------------------------------------------------------------------
// memory_param_if
// Request/response bundle for the memory_param register-file RAM.
//
// Signals
//   activate  block enable; when low, write and read requests are ignored
//   write     write request
//   read      read request
//   addrin    write address   [ADDR_WIDTH]
//   addrout   read address    [ADDR_WIDTH]
//   datain    write data      [DATA_WIDTH]
//   dataout   registered read data [DATA_WIDTH]
//   valid     dataout carries the result of a read accepted on the previous edge
//   error     the access accepted on the previous edge was illegal
//
// Modports
//   master  requester side (drives requests, observes responses)
//   slave   memory side (observes requests, drives responses)
// -----------------------------------------------------------------------------
interface memory_param_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  activate;
   logic                  write;
   logic                  read;
   logic [ADDR_WIDTH-1:0] addrin;
   logic [ADDR_WIDTH-1:0] addrout;
   logic [DATA_WIDTH-1:0] datain;
   logic [DATA_WIDTH-1:0] dataout;
   logic                  valid;
   logic                  error;

   modport master (
      output activate,
      output write,
      output read,
      output addrin,
      output addrout,
      output datain,
      input  dataout,
      input  valid,
      input  error
   );

   modport slave (
      input  activate,
      input  write,
      input  read,
      input  addrin,
      input  addrout,
      input  datain,
      output dataout,
      output valid,
      output error
   );
endinterface

// File: rtl/memory_param.sv
// -----------------------------------------------------------------------------
// memory_param
// Flip-flop based register-file RAM: one write port, one read port, one clock.
// Contents, read data and status flags are all cleared by the asynchronous
// active-low reset.
//
// Parameters
//   DATA_WIDTH   bits per word
//   ADDR_WIDTH   address bus width
//   DEPTH        implemented words, 1 <= DEPTH <= 2**ADDR_WIDTH;
//                addresses >= DEPTH are illegal
//   WRITE_FIRST  same-address read/write on one edge: 1 = read sees the new
//                datain, 0 = read sees the old contents
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    memory_param_if.slave (activate/write/read/addrin/addrout/datain in,
//          dataout/valid/error out, all outputs registered)
// -----------------------------------------------------------------------------
module memory_param #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 4,
   parameter int DEPTH       = 16,
   parameter int WRITE_FIRST = 1
) (
   input  logic           clk,
   input  logic           reset,
   memory_param_if.slave  bus
);

   // One bit wider than the address so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
   localparam bit                  WF_MODE   = (WRITE_FIRST != 0);

   // An address is legal when it falls inside the implemented words.
   function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] addr);
      return ({1'b0, addr} < DEPTH_LIM);
   endfunction

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] dataout_r;
   logic                  valid_r;
   logic                  error_r;

   logic                  we_s;
   logic                  re_s;
   logic                  wr_legal_s;
   logic                  rd_legal_s;
   logic                  same_addr_s;
   logic                  err_next_s;
   logic [DATA_WIDTH-1:0] rd_word_s;
   logic [DATA_WIDTH-1:0] rd_next_s;

   assign we_s        = bus.activate & bus.write;
   assign re_s        = bus.activate & bus.read;
   assign wr_legal_s  = addr_legal(bus.addrin);
   assign rd_legal_s  = addr_legal(bus.addrout);
   assign same_addr_s = (bus.addrin == bus.addrout);

   // Error covers both ports; an illegal write alone still flags.
   assign err_next_s  = (we_s & ~wr_legal_s) | (re_s & ~rd_legal_s);

   // Read mux as an AND-OR over one-hot address matches; illegal addresses
   // match no word and so yield zero.
   always_comb begin
      rd_word_s = {DATA_WIDTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         rd_word_s = rd_word_s
                   | (mem_r[i] & {DATA_WIDTH{bus.addrout == ADDR_WIDTH'(i)}});
      end
   end

   // Select the value captured into dataout, including write-first bypass.
   always_comb begin
      rd_next_s = {DATA_WIDTH{1'b0}};
      if (!rd_legal_s) begin
         rd_next_s = {DATA_WIDTH{1'b0}};
      end else if (WF_MODE && we_s && same_addr_s) begin
         rd_next_s = bus.datain;
      end else begin
         rd_next_s = rd_word_s;
      end
   end

   // Storage array: cleared by reset, written only at legal addresses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {DATA_WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (we_s && (bus.addrin == ADDR_WIDTH'(i))) begin
               mem_r[i] <= bus.datain;
            end
         end
      end
   end

   // Registered read response and status; dataout holds when no read occurs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataout_r <= {DATA_WIDTH{1'b0}};
         valid_r   <= 1'b0;
         error_r   <= 1'b0;
      end else begin
         valid_r <= re_s;
         error_r <= err_next_s;
         if (re_s) begin
            dataout_r <= rd_next_s;
         end
      end
   end

   assign bus.dataout = dataout_r;
   assign bus.valid   = valid_r;
   assign bus.error   = error_r;

endmodule

// File: doc/memory_param.md
Name: memory_param

Overview:
- Parametrised successor to the team's 16x8 latch memory: a synchronous register-file RAM with one write port, one read port and a single clock.
- Adds configurable width, depth and read-during-write mode, plus a registered read with a valid strobe and a per-access error flag for illegal accesses.
- Sits on the datapath as general scratch storage. It is built from flip-flops, not D-latches, so its contents are clearable by reset.

Parameters:
- DATA_WIDTH, 8, bits per word.
- ADDR_WIDTH, 4, address bus width.
- DEPTH, 16, number of implemented words. Must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH. Addresses >= DEPTH are illegal.
- WRITE_FIRST, 1. On a same-address read/write in one cycle: 1 = read returns the new datain; 0 = read returns the old contents.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- activate  input  1  block enable; when 0, write and read are ignored.
- write  input  1  write request, sampled on the rising edge.
- read  input  1  read request, sampled on the rising edge.
- addrin  input  ADDR_WIDTH  write address.
- addrout  input  ADDR_WIDTH  read address.
- datain  input  DATA_WIDTH  write data.
- dataout  output  DATA_WIDTH  registered read data.
- valid  output  1  dataout holds the result of a read accepted on the previous edge.
- error  output  1  the access accepted on the previous edge was illegal.

Behaviour:
- Reset (reset=0, asynchronous, no clock required):
  - all DEPTH words = 0
  - dataout = 0, valid = 0, error = 0
  - state stays held while reset=0; normal operation resumes on the first rising edge after reset returns to 1.
- Reset asserted mid-operation:
  - any write or read in flight is discarded
  - outputs clear immediately (asynchronously), not at the next edge.
- Write request: we = activate & write.
- Legal write: on the edge where we=1 and addrin < DEPTH, mem[addrin] <= datain.
- Illegal write (addrin >= DEPTH): memory unchanged, write error raised.
- Read request: re = activate & read.
- Read latency is 1 cycle. On an edge with re=1:
  - valid <= 1
  - if addrout < DEPTH: dataout <= mem[addrout]
  - if addrout >= DEPTH: dataout <= 0 and read error raised.
- When re=0 on an edge: valid <= 0 and dataout holds its previous value. dataout is not cleared.
- Read and write to the same legal address on the same edge:
  - WRITE_FIRST=1: dataout <= datain
  - WRITE_FIRST=0: dataout <= old mem contents
  - the memory is updated in both modes.
- Read and write to different addresses on the same edge: fully independent.
- error is registered, one cycle after the access, and not sticky:
  - error <= (we & addrin>=DEPTH) | (re & addrout>=DEPTH)
  - error asserts regardless of whether valid asserts, so an illegal write-only access still flags.
- activate=0:
  - no memory update
  - valid <= 0, error <= 0
  - dataout holds.
- Back-to-back reads on consecutive cycles: valid stays high and dataout updates every cycle, giving full throughput.
- With DEPTH = 2**ADDR_WIDTH no address is illegal, so error stays 0 forever.
- No X on outputs after reset under any input sequence with known inputs.

Test Plan:
- Reset, then read every address 0..DEPTH-1 -> each read returns dataout=0x00 one cycle later with valid=1 and error=0.
- Write 0xA5 to address 3, then read address 3 on the next edge -> after one cycle, dataout=0xA5, valid=1, error=0. With read=0 on the following edge -> valid=0 and dataout still 0xA5.
- Write address 5 = 0x11. Then on one edge, write address 5 = 0x22 and read address 5:
  - WRITE_FIRST=1 -> dataout=0x22
  - WRITE_FIRST=0 -> dataout=0x11
  - a subsequent read of address 5 -> 0x22 in both modes.
- DEPTH=12, ADDR_WIDTH=4:
  - write 0x77 to address 13 -> error=1 for one cycle and valid=0
  - read address 13 -> dataout=0, valid=1, error=1
  - read addresses 0..11 -> all unchanged.
- activate=0 with write=1 to address 2 = 0xFF and read=1 -> no change: valid=0, error=0, and a later read of address 2 returns its prior value.
- Write address 1 = 0x3C. Assert reset low between clock edges -> dataout, valid and error go to 0 immediately. After release, reading address 1 -> 0x00.
